// File: rtl/pri_arb_pkg.sv
// Shared definitions for the registered priority / round-robin arbiter.
package pri_arb_pkg;

    // Arbitration mode encoding as seen on the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Arbiter control state: no grant held, or a grant awaiting ack.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for tiny N.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pri_enc_param.sv
// Combinational highest-index-first priority encoder.
module pri_enc_param
    import pri_arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the highest set bit is the last one to write idx.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = req[i] ? W'(i) : idx;
            any = any | req[i];
        end
    end

endmodule

// File: rtl/pri_arb_rr.sv
// Registered N-way arbiter, fixed priority or round-robin, grant held until ack.
module pri_arb_rr
    import pri_arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    localparam logic [W-1:0] PTR_MAX = W'(N - 1);
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};

    arb_state_t   state_r;
    arb_state_t   state_next_s;
    logic [W-1:0] ptr_r;
    logic [W-1:0] arb_ptr_s;
    logic         arb_en_s;
    logic [N-1:0] mask_s;
    logic [N-1:0] masked_req_s;
    logic [W-1:0] m_idx_s;
    logic         m_any_s;
    logic [W-1:0] u_idx_s;
    logic         u_any_s;
    logic [W-1:0] winner_s;
    logic         valid_next_s;
    logic [W-1:0] idx_next_s;
    logic [N-1:0] onehot_next_s;

    // Build the round-robin mask (bits 0..arb_ptr) from the pointer used for this arbitration.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (i <= int'(arb_ptr_s));
        end
        masked_req_s = req & mask_s;
    end

    pri_enc_param #(.N(N)) u_enc_masked (
        .req (masked_req_s),
        .idx (m_idx_s),
        .any (m_any_s)
    );

    pri_enc_param #(.N(N)) u_enc_raw (
        .req (req),
        .idx (u_idx_s),
        .any (u_any_s)
    );

    // Pick the winner: masked search in RR mode, falling back to the raw search.
    always_comb begin
        if ((mode == MODE_RR) && m_any_s) begin
            winner_s = m_idx_s;
        end else begin
            winner_s = u_idx_s;
        end
    end

    // Next-state logic: decide when to arbitrate and which pointer that arbitration uses.
    always_comb begin
        state_next_s = state_r;
        arb_en_s     = 1'b0;
        arb_ptr_s    = ptr_r;
        case (state_r)
            IDLE: begin
                arb_en_s = u_any_s;
                if (u_any_s) begin
                    state_next_s = GRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                if (ack) begin
                    arb_en_s = 1'b1;
                    if (mode == MODE_RR) begin
                        arb_ptr_s = (gnt_idx == '0) ? PTR_MAX : (gnt_idx - W'(1));
                    end else begin
                        arb_ptr_s = ptr_r;
                    end
                    state_next_s = u_any_s ? GRANT : IDLE;
                end else begin
                    state_next_s = GRANT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output next values: load a new grant, clear on drain, otherwise hold.
    always_comb begin
        valid_next_s  = gnt_valid;
        idx_next_s    = gnt_idx;
        onehot_next_s = gnt_onehot;
        if (arb_en_s) begin
            if (u_any_s) begin
                valid_next_s  = 1'b1;
                idx_next_s    = winner_s;
                onehot_next_s = ONE_N << winner_s;
            end else begin
                valid_next_s  = 1'b0;
                idx_next_s    = '0;
                onehot_next_s = '0;
            end
        end else begin
            valid_next_s  = gnt_valid;
            idx_next_s    = gnt_idx;
            onehot_next_s = gnt_onehot;
        end
    end

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= PTR_MAX;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= arb_ptr_s;
        end
    end

    // Registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            gnt_valid  <= valid_next_s;
            gnt_idx    <= idx_next_s;
            gnt_onehot <= onehot_next_s;
        end
    end

endmodule

// File: tb/tb_pri_arb_rr.sv
// Directed self-checking bench for pri_arb_rr at N=4, N=8 and N=5.
module tb_pri_arb_rr;

    logic clk = 1'b0;
    logic rst_n;

    logic [3:0] req4;
    logic       mode4, ack4, valid4;
    logic [1:0] idx4;
    logic [3:0] oh4;

    logic [7:0] req8;
    logic       mode8, ack8, valid8;
    logic [2:0] idx8;
    logic [7:0] oh8;

    logic [4:0] req5;
    logic       mode5, ack5, valid5;
    logic [2:0] idx5;
    logic [4:0] oh5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pri_arb_rr #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .mode(mode4), .ack(ack4),
        .gnt_valid(valid4), .gnt_idx(idx4), .gnt_onehot(oh4)
    );

    pri_arb_rr #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .ack(ack8),
        .gnt_valid(valid8), .gnt_idx(idx8), .gnt_onehot(oh8)
    );

    pri_arb_rr #(.N(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .ack(ack5),
        .gnt_valid(valid5), .gnt_idx(idx5), .gnt_onehot(oh5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_seq[8];
    logic [1:0] sp_seq[4];
    logic [2:0] s8_seq[3];
    logic [2:0] s5_seq[3];

    initial begin
        rr_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        sp_seq = '{2'd3, 2'd1, 2'd3, 2'd1};
        s8_seq = '{3'd0, 3'd7, 3'd0};
        s5_seq = '{3'd0, 3'd4, 3'd0};

        rst_n = 1'b0;
        req4 = 4'b0000; mode4 = 1'b0; ack4 = 1'b0;
        req8 = 8'h00;   mode8 = 1'b0; ack8 = 1'b0;
        req5 = 5'b00000; mode5 = 1'b0; ack5 = 1'b0;
        #1;
        chk("reset_valid4", valid4, 1'b0);
        chk("reset_idx4", idx4, 2'd0);
        chk("reset_oh4", oh4, 4'b0000);
        chk("reset_valid8", valid8, 1'b0);
        chk("reset_valid5", valid5, 1'b0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fixed mode: grant, hold against req changes, back-to-back re-grant.
        req4 = 4'b0101;
        step();
        chk("fix_valid", valid4, 1'b1);
        chk("fix_idx", idx4, 2'd2);
        chk("fix_oh", oh4, 4'b0100);
        req4 = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_idx", idx4, 2'd2);
            chk("hold_oh", oh4, 4'b0100);
            chk("hold_valid", valid4, 1'b1);
        end
        req4 = 4'b0101; ack4 = 1'b1;
        step();
        chk("b2b_idx", idx4, 2'd2);
        chk("b2b_valid", valid4, 1'b1);

        // Drain to IDLE in fixed mode (pointer stays at 3).
        req4 = 4'b0000;
        step();
        chk("drain1_valid", valid4, 1'b0);

        // Round-robin fairness with all requesting.
        mode4 = 1'b1; req4 = 4'b1111; ack4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_idx", idx4, rr_seq[i]);
            chk("rr_valid", valid4, 1'b1);
            chk("rr_oh", oh4, 4'b0001 << rr_seq[i]);
        end
        // Drain from idx 0 in RR mode: pointer wraps to 3.
        req4 = 4'b0000;
        step();
        chk("drain2_valid", valid4, 1'b0);

        // Round-robin sparse requests.
        req4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sparse_idx", idx4, sp_seq[i]);
            chk("sparse_valid", valid4, 1'b1);
        end
        req4 = 4'b0000;
        step();
        chk("sparse_end_valid", valid4, 1'b0);
        chk("sparse_end_oh", oh4, 4'b0000);
        chk("sparse_end_idx", idx4, 2'd0);

        // Spurious ack while idle.
        for (int i = 0; i < 5; i++) begin
            ack4 = ~ack4;
            step();
            chk("idle_ack_valid", valid4, 1'b0);
        end
        ack4 = 1'b0; req4 = 4'b0010;
        #1;
        chk("latency_pre_valid", valid4, 1'b0);
        step();
        chk("latency_valid", valid4, 1'b1);
        chk("latency_idx", idx4, 2'd1);

        // Move grant to idx 2 (pointer now 0), then reset mid-grant.
        req4 = 4'b0100; ack4 = 1'b1;
        step();
        chk("pre_rst_idx", idx4, 2'd2);
        ack4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid4, 1'b0);
        chk("async_rst_idx", idx4, 2'd0);
        chk("async_rst_oh", oh4, 4'b0000);
        req4 = 4'b1111; mode4 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_idx", idx4, 2'd3);
        chk("post_rst_valid", valid4, 1'b1);

        // N=8 fixed then round-robin.
        req8 = 8'h81;
        step();
        chk("n8_fix_idx", idx8, 3'd7);
        chk("n8_fix_oh", oh8, 8'h80);
        mode8 = 1'b1; ack8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("n8_rr_idx", idx8, s8_seq[i]);
            chk("n8_rr_valid", valid8, 1'b1);
        end

        // N=5 non-power-of-two.
        req5 = 5'b10000;
        step();
        chk("n5_idx", idx5, 3'd4);
        chk("n5_oh", oh5, 5'b10000);
        req5 = 5'b10001; mode5 = 1'b1; ack5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("n5_rr_idx", idx5, s5_seq[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
